// File: rtl/sprite_pkg.sv
// Shared types for the sprite compositor: colour words, direction frame encoding, RGB split.
package sprite_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t KeyRgbDefault = 24'hFF0000;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirRight = 2'd1,
    DirLeft  = 2'd2,
    DirDown  = 2'd3
  } dir_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_split_t;

  function automatic rgb_split_t split_rgb(input rgb_t c);
    rgb_split_t s;
    s.r = c[23:16];
    s.g = c[15:8];
    s.b = c[7:0];
    return s;
  endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// Per-sprite hit test and ROM address generation; registers both (pipeline stage S0).
module sprite_hit_addr #(
  parameter int unsigned SPR_W   = 32,
  parameter int unsigned SPR_H   = 32,
  parameter int unsigned FRAME_W = 2,
  localparam int unsigned XB     = $clog2(SPR_W),
  localparam int unsigned YB     = $clog2(SPR_H),
  localparam int unsigned ADDR_W = FRAME_W + XB + YB
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               en_i,
  input  logic               pix_valid_i,
  input  logic [9:0]         draw_x_i,
  input  logic [9:0]         draw_y_i,
  input  logic [9:0]         x_i,
  input  logic [9:0]         y_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               hit_o,
  output logic [ADDR_W-1:0]  addr_o
);

  logic [10:0]       x_end, y_end;
  logic              in_x, in_y, hit_d;
  logic [XB-1:0]     dx;
  logic [YB-1:0]     dy;
  logic [ADDR_W-1:0] addr_d;
  logic              hit_q;
  logic [ADDR_W-1:0] addr_q;

  // 11-bit compare so a sprite hanging off the right/bottom edge does not wrap to 0
  always_comb begin
    x_end  = {1'b0, x_i} + 11'(SPR_W);
    y_end  = {1'b0, y_i} + 11'(SPR_H);
    in_x   = ({1'b0, draw_x_i} >= {1'b0, x_i}) && ({1'b0, draw_x_i} < x_end);
    in_y   = ({1'b0, draw_y_i} >= {1'b0, y_i}) && ({1'b0, draw_y_i} < y_end);
    dx     = XB'(draw_x_i - x_i);
    dy     = YB'(draw_y_i - y_i);
    hit_d  = en_i & pix_valid_i & in_x & in_y;
    addr_d = hit_d ? {frame_i, dy, dx} : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      hit_q  <= hit_d;
      addr_q <= addr_d;
    end
  end

  assign hit_o  = hit_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/sprite_compositor.sv
// N-sprite pixel compositor: priority select of opaque sprite pixels over background,
// plus per-frame sprite collision flags. Fixed latency 2+ROM_LAT, one pixel per cycle.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int unsigned N_SPR   = 4,
  parameter int unsigned SPR_W   = 32,
  parameter int unsigned SPR_H   = 32,
  parameter int unsigned FRAME_W = 2,
  parameter int unsigned ROM_LAT = 1,
  parameter rgb_t        KEY_RGB = KeyRgbDefault,
  localparam int unsigned ADDR_W = FRAME_W + $clog2(SPR_W) + $clog2(SPR_H)
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_start,
  input  logic                           pix_valid_i,
  input  logic [9:0]                     DrawX,
  input  logic [9:0]                     DrawY,
  input  logic [23:0]                    bg_rgb,
  input  logic [N_SPR-1:0]               spr_en,
  input  logic [N_SPR-1:0][9:0]          spr_x,
  input  logic [N_SPR-1:0][9:0]          spr_y,
  input  logic [N_SPR-1:0][FRAME_W-1:0]  spr_frame,
  output logic [N_SPR-1:0][ADDR_W-1:0]   rom_addr,
  input  logic [N_SPR-1:0][23:0]         rom_data,
  output logic [7:0]                     VGA_R,
  output logic [7:0]                     VGA_G,
  output logic [7:0]                     VGA_B,
  output logic                           pix_valid_o,
  output logic [N_SPR-1:0]               collide_o,
  output logic                           collide_vld
);

  logic [N_SPR-1:0] hit_s0;

  for (genvar i = 0; i < N_SPR; i++) begin : g_spr
    sprite_hit_addr #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .FRAME_W (FRAME_W)
    ) u_hit (
      .Clk         (Clk),
      .Reset       (Reset),
      .en_i        (spr_en[i]),
      .pix_valid_i (pix_valid_i),
      .draw_x_i    (DrawX),
      .draw_y_i    (DrawY),
      .x_i         (spr_x[i]),
      .y_i         (spr_y[i]),
      .frame_i     (spr_frame[i]),
      .hit_o       (hit_s0[i]),
      .addr_o      (rom_addr[i])
    );
  end

  // Hits lag the S0 register by ROM_LAT; bg/valid also include the S0 stage itself
  logic [N_SPR-1:0] hit_dl_q [ROM_LAT];
  rgb_t             bg_dl_q  [ROM_LAT+1];
  logic [ROM_LAT:0] pv_dl_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < ROM_LAT; k++) hit_dl_q[k] <= '0;
      for (int k = 0; k <= ROM_LAT; k++) bg_dl_q[k] <= '0;
      pv_dl_q <= '0;
    end else begin
      hit_dl_q[0] <= hit_s0;
      for (int k = 1; k < ROM_LAT; k++) hit_dl_q[k] <= hit_dl_q[k-1];
      bg_dl_q[0] <= bg_rgb;
      for (int k = 1; k <= ROM_LAT; k++) bg_dl_q[k] <= bg_dl_q[k-1];
      pv_dl_q <= {pv_dl_q[ROM_LAT-1:0], pix_valid_i};
    end
  end

  logic [N_SPR-1:0] hit_d, opaque, contrib, acc_d, acc_q, collide_q;
  logic [3:0]       n_opaque;
  rgb_t             bg_d, pix;
  logic             pv_d, vld_q;
  rgb_split_t       vga_q;

  assign hit_d = hit_dl_q[ROM_LAT-1];
  assign bg_d  = bg_dl_q[ROM_LAT];
  assign pv_d  = pv_dl_q[ROM_LAT];

  always_comb begin
    opaque   = '0;
    n_opaque = '0;
    pix      = bg_d;
    for (int i = 0; i < N_SPR; i++) begin
      opaque[i] = hit_d[i] && (rom_data[i] != KEY_RGB);
      n_opaque  = n_opaque + 4'(opaque[i]);
    end
    // Scan high to low so the lowest opaque index lands last and wins
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) pix = rom_data[i];
    end
    if (!pv_d) pix = '0;
    contrib = (n_opaque >= 4'd2) ? opaque : '0;
    // The overlap seen on the frame_start cycle belongs to the new frame
    acc_d   = frame_start ? contrib : (acc_q | contrib);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vga_q       <= '0;
      pix_valid_o <= 1'b0;
      acc_q       <= '0;
      collide_q   <= '0;
      vld_q       <= 1'b0;
    end else begin
      vga_q       <= split_rgb(pix);
      pix_valid_o <= pv_d;
      acc_q       <= acc_d;
      vld_q       <= frame_start;
      if (frame_start) collide_q <= acc_q;
    end
  end

  assign VGA_R       = vga_q.r;
  assign VGA_G       = vga_q.g;
  assign VGA_B       = vga_q.b;
  assign collide_o   = collide_q;
  assign collide_vld = vld_q;

endmodule
